// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execution unit with a 2-entry result buffer between the
// operand handshake and the writeback handshake. Define ALU_EXEC_OVF_EN to add out_overflow.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
`ifdef ALU_EXEC_OVF_EN
    output logic             out_overflow,
`endif
    output logic             out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on registered count, so out_ready never reaches it.
    logic             push;
    logic             pop;
    logic [1:0]       count;
    logic             head;
    logic             tail;

    logic [WIDTH-1:0] res_mem [2];
    logic             zero_mem [2];
    logic             ill_mem [2];

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             alu_ill;
    logic             slt_bit;

    assign sum     = in_a + in_b;
    assign diff    = in_a - in_b;
    assign slt_bit = ($signed(in_a) < $signed(in_b));

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (in_op)
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_XOR:  alu_res = in_a ^ in_b;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_OVF_EN
    logic alu_ovf;
    logic ovf_mem [2];

    always_comb begin
        alu_ovf = 1'b0;
        if (in_op == OP_ADD)
            alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
        else if (in_op == OP_SUB)
            alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_mem[0] <= 1'b0;
            ovf_mem[1] <= 1'b0;
        end else if (push) begin
            ovf_mem[tail] <= alu_ovf;
        end
    end

    assign out_overflow = ovf_mem[head];
`endif

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                res_mem[i]  <= '0;
                zero_mem[i] <= 1'b0;
                ill_mem[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                res_mem[tail]  <= alu_res;
                zero_mem[tail] <= (alu_res == '0);
                ill_mem[tail]  <= alu_ill;
                tail           <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Empty buffer still drives the (cleared or stale) head entry, never X.
    assign out_result  = res_mem[head];
    assign out_zero    = zero_mem[head];
    assign out_illegal = ill_mem[head];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit; overflow checks compile in with ALU_EXEC_OVF_EN.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_illegal;
`ifdef ALU_EXEC_OVF_EN
    logic         out_overflow;
`endif

    int n_checks;
    int n_fail;
    logic [W-1:0] exp_q[$];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
`ifdef ALU_EXEC_OVF_EN
        .out_overflow(out_overflow),
`endif
        .out_illegal (out_illegal)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: all drives and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, '0, '0);
        out_ready = 1'b0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_result got %0h exp 0", out_result); end
        n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %0h exp 0", out_zero); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0h exp 0", out_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'd5, 32'd7);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0h exp 1", out_valid); end
        n_checks++; if (out_result !== 32'd12) begin n_fail++; $display("FAIL add_result got %0h exp c", out_result); end
        n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %0h exp 0", out_zero); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %0h exp 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 4'b0110, 32'd9, 32'd9);
        tick();
        drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        n_checks++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_sub got %0h/%0h exp 0/1", out_result, out_zero); end
        tick();
        drive(1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'd1) begin n_fail++; $display("FAIL b2b_slt_neg got %0h/%0h exp 1/1", out_valid, out_result); end
        n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_slt_neg_zero got %0h exp 0", out_zero); end
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_slt_pos got %0h/%0h/%0h exp 1/0/1", out_valid, out_result, out_zero); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        exp_q.push_back(32'h30);
        exp_q.push_back(32'h3F);
        exp_q.push_back(32'hF0);
        drive(1'b1, 4'b0000, 32'hF0, 32'h3C);
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready1 got %0h exp 1", in_ready); end
        drive(1'b1, 4'b0001, 32'h0F, 32'h30);
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got %0h exp 0", in_ready); end
        drive(1'b1, 4'b1100, 32'hFF, 32'h0F);
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold_ready got %0h exp 0", in_ready); end
        n_checks++; if (out_result !== exp_q[0]) begin n_fail++; $display("FAIL stall_stable got %0h exp %0h", out_result, exp_q[0]); end
        out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_return got %0h exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_result !== exp_q[0]) begin n_fail++; $display("FAIL stall_second got %0h/%0h exp 1/%0h", out_valid, out_result, exp_q[0]); end
        tick();
        void'(exp_q.pop_front());
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_valid !== 1'b1 || out_result !== exp_q[0]) begin n_fail++; $display("FAIL stall_third got %0h/%0h exp 1/%0h", out_valid, out_result, exp_q[0]); end
        tick();
        void'(exp_q.pop_front());
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 4'b1111, 32'd3, 32'd4);
        tick();
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL ill_result got %0h exp 0", out_result); end
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %0h exp 1", out_illegal); end
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL ill_zero got %0h exp 1", out_zero); end
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_result !== 32'd2) begin n_fail++; $display("FAIL ill_next_result got %0h exp 2", out_result); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_next_flag got %0h exp 0", out_illegal); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd1, 32'd2);
        tick();
        drive(1'b1, 4'b0010, 32'd3, 32'd4);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'd3) begin n_fail++; $display("FAIL arst_pre got %0h/%0h/%0h exp 1/0/3", out_valid, in_ready, out_result); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0h exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %0h exp 1", in_ready); end
        n_checks++; if (out_result !== '0 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL arst_outputs got %0h/%0h/%0h exp 0/0/0", out_result, out_zero, out_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'd10, 32'd20);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'd30) begin n_fail++; $display("FAIL arst_new got %0h/%0h exp 1/1e", out_valid, out_result); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_only_one got %0h exp 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_still_empty got %0h exp 0", out_valid); end
    endtask

`ifdef ALU_EXEC_OVF_EN
    task automatic test_overflow();
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1);
        tick();
        drive(1'b1, 4'b0110, 32'h8000_0000, 32'd1);
        n_checks++; if (out_overflow !== 1'b1 || out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_add got %0h/%0h exp 1/80000000", out_overflow, out_result); end
        tick();
        drive(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (out_overflow !== 1'b1 || out_result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_sub got %0h/%0h exp 1/7fffffff", out_overflow, out_result); end
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_and got %0h exp 0", out_overflow); end
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_async_reset();
`ifdef ALU_EXEC_OVF_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
